// File: rtl/mem_arbiter.sv
// Shares one external SRAM between instruction fetch and data access. Data wins
// ties; each access is a registered IDLE -> ACCESS -> DONE sequence.
module mem_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_done_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_done_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic              sram_drive_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} ArbState;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES);

    ArbState state;
    logic [3:0] cnt;
    logic grantData;
    logic isWrite;
    logic grantWrite;

    assign grantWrite = data_req_i & data_we_i;

    // Stall stays combinational so the pipeline freezes in the same cycle a request appears.
    assign stall_o = (inst_req_i & ~inst_done_o) | (data_req_i & ~data_done_o);

    // The SRAM pins are registered, so they are set up on the granting edge and
    // released on the edge that leaves ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            grantData    <= 1'b0;
            isWrite      <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            sram_drive_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            inst_rdata_o <= '0;
            inst_done_o  <= 1'b0;
            data_rdata_o <= '0;
            data_done_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_req_i || inst_req_i) begin
                        grantData    <= data_req_i;
                        isWrite      <= grantWrite;
                        sram_addr_o  <= data_req_i ? data_addr_i : inst_addr_i;
                        if (grantWrite) begin
                            sram_wdata_o <= data_wdata_i;
                        end
                        sram_ce_n_o  <= 1'b0;
                        sram_oe_n_o  <= grantWrite;
                        sram_we_n_o  <= ~grantWrite;
                        sram_drive_o <= grantWrite;
                        cnt          <= 4'd0;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LastCnt) begin
                        if (grantData) begin
                            data_done_o <= 1'b1;
                            if (!isWrite) begin
                                data_rdata_o <= sram_rdata_i;
                            end
                        end else begin
                            inst_done_o  <= 1'b1;
                            inst_rdata_o <= sram_rdata_i;
                        end
                        sram_ce_n_o  <= 1'b1;
                        sram_oe_n_o  <= 1'b1;
                        sram_we_n_o  <= 1'b1;
                        sram_drive_o <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    inst_done_o <= 1'b0;
                    data_done_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT_CYCLES=1 instance with an SRAM model,
// plus WAIT_CYCLES=0 and 3 instances for back-to-back fetch timing.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic        instReq;
    logic [19:0] instAddr;
    logic [31:0] instRdata;
    logic        instDone;
    logic        dataReq;
    logic        dataWe;
    logic [19:0] dataAddr;
    logic [31:0] dataWdata;
    logic [31:0] dataRdata;
    logic        dataDone;
    logic        stall;
    logic [19:0] sramAddr;
    logic [31:0] sramWdata;
    logic        sramDrive;
    logic [31:0] sramRdata;
    logic        sramCeN;
    logic        sramOeN;
    logic        sramWeN;

    logic        tieLow;
    logic [19:0] tieAddr;
    logic [31:0] tieData;

    logic        w0InstReq, w3InstReq;
    logic [19:0] w0InstAddr, w3InstAddr;
    logic [31:0] w0InstRdata, w3InstRdata;
    logic        w0InstDone, w3InstDone;
    logic [31:0] w0DataRdata, w3DataRdata;
    logic        w0DataDone, w3DataDone;
    logic        w0Stall, w3Stall;
    logic [19:0] w0SramAddr, w3SramAddr;
    logic [31:0] w0SramWdata, w3SramWdata;
    logic        w0SramDrive, w3SramDrive;
    logic [31:0] w0SramRdata, w3SramRdata;
    logic        w0CeN, w3CeN;
    logic        w0OeN, w3OeN;
    logic        w0WeN, w3WeN;

    logic [31:0] mem [0:1023];

    int checkCount = 0;
    int passCount  = 0;

    mem_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) dutMain (
        .clk(clk), .rst(rst),
        .inst_req_i(instReq), .inst_addr_i(instAddr),
        .inst_rdata_o(instRdata), .inst_done_o(instDone),
        .data_req_i(dataReq), .data_we_i(dataWe), .data_addr_i(dataAddr),
        .data_wdata_i(dataWdata), .data_rdata_o(dataRdata), .data_done_o(dataDone),
        .stall_o(stall), .sram_addr_o(sramAddr), .sram_wdata_o(sramWdata),
        .sram_drive_o(sramDrive), .sram_rdata_i(sramRdata),
        .sram_ce_n_o(sramCeN), .sram_oe_n_o(sramOeN), .sram_we_n_o(sramWeN)
    );

    mem_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(0)) dutWait0 (
        .clk(clk), .rst(rst),
        .inst_req_i(w0InstReq), .inst_addr_i(w0InstAddr),
        .inst_rdata_o(w0InstRdata), .inst_done_o(w0InstDone),
        .data_req_i(tieLow), .data_we_i(tieLow), .data_addr_i(tieAddr),
        .data_wdata_i(tieData), .data_rdata_o(w0DataRdata), .data_done_o(w0DataDone),
        .stall_o(w0Stall), .sram_addr_o(w0SramAddr), .sram_wdata_o(w0SramWdata),
        .sram_drive_o(w0SramDrive), .sram_rdata_i(w0SramRdata),
        .sram_ce_n_o(w0CeN), .sram_oe_n_o(w0OeN), .sram_we_n_o(w0WeN)
    );

    mem_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(3)) dutWait3 (
        .clk(clk), .rst(rst),
        .inst_req_i(w3InstReq), .inst_addr_i(w3InstAddr),
        .inst_rdata_o(w3InstRdata), .inst_done_o(w3InstDone),
        .data_req_i(tieLow), .data_we_i(tieLow), .data_addr_i(tieAddr),
        .data_wdata_i(tieData), .data_rdata_o(w3DataRdata), .data_done_o(w3DataDone),
        .stall_o(w3Stall), .sram_addr_o(w3SramAddr), .sram_wdata_o(w3SramWdata),
        .sram_drive_o(w3SramDrive), .sram_rdata_i(w3SramRdata),
        .sram_ce_n_o(w3CeN), .sram_oe_n_o(w3OeN), .sram_we_n_o(w3WeN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM: data appears whenever chip and output enables are low.
    assign sramRdata   = (!sramCeN && !sramOeN) ? mem[sramAddr[9:0]] : 32'h0;
    assign w0SramRdata = (!w0CeN && !w0OeN) ? (32'hC0DE0000 | {12'h0, w0SramAddr}) : 32'h0;
    assign w3SramRdata = (!w3CeN && !w3OeN) ? (32'hC0DE0000 | {12'h0, w3SramAddr}) : 32'h0;

    always @(posedge clk) begin
        if (!sramCeN && !sramWeN) begin
            mem[sramAddr[9:0]] <= sramWdata;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] <= 32'hC0DE0000 | 32'(i);
        end
        mem[16] <= 32'hDEADBEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iReq, input logic [19:0] iAddr, input logic dReq,
                                 input logic dWe, input logic [19:0] dAddr, input logic [31:0] dWdata);
        instReq   = iReq;
        instAddr  = iAddr;
        dataReq   = dReq;
        dataWe    = dWe;
        dataAddr  = dAddr;
        dataWdata = dWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        tieLow = 1'b0; tieAddr = '0; tieData = '0;
        w0InstReq = 1'b0; w0InstAddr = '0;
        w3InstReq = 1'b0; w3InstAddr = '0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        checkOutput("reset ce_n", {31'h0, sramCeN}, 32'h1);
        checkOutput("reset oe_n", {31'h0, sramOeN}, 32'h1);
        checkOutput("reset we_n", {31'h0, sramWeN}, 32'h1);
        checkOutput("reset drive", {31'h0, sramDrive}, 32'h0);
        checkOutput("reset addr", {12'h0, sramAddr}, 32'h0);
        checkOutput("reset wdata", sramWdata, 32'h0);
        checkOutput("reset dones", {30'h0, instDone, dataDone}, 32'h0);
        checkOutput("reset inst rdata", instRdata, 32'h0);
        checkOutput("reset data rdata", dataRdata, 32'h0);
        #2 rst = 1'b1;

        // Single fetch
        nextCycle();
        applyStimulus(1, 20'h10, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 c0 stall", {31'h0, stall}, 32'h1);
        checkOutput("t1 c0 ce_n", {31'h0, sramCeN}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t1 c1 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t1 c1 oe_n", {31'h0, sramOeN}, 32'h0);
        checkOutput("t1 c1 addr", {12'h0, sramAddr}, 32'h10);
        checkOutput("t1 c1 stall", {31'h0, stall}, 32'h1);
        checkOutput("t1 c1 done", {31'h0, instDone}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t1 c2 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t1 c2 done", {31'h0, instDone}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t1 c3 done", {31'h0, instDone}, 32'h1);
        checkOutput("t1 c3 rdata", instRdata, 32'hDEADBEEF);
        checkOutput("t1 c3 ce_n", {31'h0, sramCeN}, 32'h1);
        checkOutput("t1 c3 oe_n", {31'h0, sramOeN}, 32'h1);
        checkOutput("t1 c3 stall", {31'h0, stall}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t1 c4 done", {31'h0, instDone}, 32'h0);
        checkOutput("t1 c4 ce_n", {31'h0, sramCeN}, 32'h1);

        // Simultaneous requests: data write wins
        nextCycle();
        applyStimulus(1, 20'h4, 1, 1, 20'h100, 32'h12345678);
        @(negedge clk);
        checkOutput("t2 c0 stall", {31'h0, stall}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t2 c1 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t2 c1 we_n", {31'h0, sramWeN}, 32'h0);
        checkOutput("t2 c1 oe_n", {31'h0, sramOeN}, 32'h1);
        checkOutput("t2 c1 drive", {31'h0, sramDrive}, 32'h1);
        checkOutput("t2 c1 addr", {12'h0, sramAddr}, 32'h100);
        checkOutput("t2 c1 wdata", sramWdata, 32'h12345678);
        nextCycle(); @(negedge clk);
        checkOutput("t2 c2 we_n", {31'h0, sramWeN}, 32'h0);
        nextCycle();
        applyStimulus(1, 20'h4, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2 c3 data done", {31'h0, dataDone}, 32'h1);
        checkOutput("t2 c3 inst done", {31'h0, instDone}, 32'h0);
        checkOutput("t2 c3 data rdata", dataRdata, 32'h0);
        checkOutput("t2 c3 drive", {31'h0, sramDrive}, 32'h0);
        checkOutput("t2 c3 stall", {31'h0, stall}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t2 c4 ce_n", {31'h0, sramCeN}, 32'h1);
        checkOutput("t2 c4 data done", {31'h0, dataDone}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t2 c5 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t2 c5 oe_n", {31'h0, sramOeN}, 32'h0);
        checkOutput("t2 c5 addr", {12'h0, sramAddr}, 32'h4);
        checkOutput("t2 c5 drive", {31'h0, sramDrive}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t2 c6 inst done", {31'h0, instDone}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t2 c7 inst done", {31'h0, instDone}, 32'h1);
        checkOutput("t2 c7 inst rdata", instRdata, 32'hC0DE0004);
        checkOutput("t2 mem[0x100]", mem[256], 32'h12345678);

        // Data read arriving during an in-flight fetch
        nextCycle();
        applyStimulus(1, 20'h20, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(1, 20'h20, 1, 0, 20'h100, 0);
        @(negedge clk);
        checkOutput("t3 c1 addr", {12'h0, sramAddr}, 32'h20);
        checkOutput("t3 c1 oe_n", {31'h0, sramOeN}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t3 c2 addr", {12'h0, sramAddr}, 32'h20);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 20'h100, 0);
        @(negedge clk);
        checkOutput("t3 c3 inst done", {31'h0, instDone}, 32'h1);
        checkOutput("t3 c3 inst rdata", instRdata, 32'hC0DE0020);
        checkOutput("t3 c3 data done", {31'h0, dataDone}, 32'h0);
        checkOutput("t3 c3 stall", {31'h0, stall}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t3 c4 ce_n", {31'h0, sramCeN}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t3 c5 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t3 c5 addr", {12'h0, sramAddr}, 32'h100);
        checkOutput("t3 c5 we_n", {31'h0, sramWeN}, 32'h1);
        checkOutput("t3 c5 inst rdata", instRdata, 32'hC0DE0020);
        nextCycle(); @(negedge clk);
        checkOutput("t3 c6 data done", {31'h0, dataDone}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t3 c7 data done", {31'h0, dataDone}, 32'h1);
        checkOutput("t3 c7 data rdata", dataRdata, 32'h12345678);
        checkOutput("t3 c7 inst rdata", instRdata, 32'hC0DE0020);
        checkOutput("t3 c7 inst done", {31'h0, instDone}, 32'h0);

        // Asynchronous reset in the middle of an access
        nextCycle();
        applyStimulus(1, 20'h30, 0, 0, 0, 0);
        nextCycle();
        checkOutput("t4 c1 ce_n", {31'h0, sramCeN}, 32'h0);
        #2 rst = 1'b0;
        #1;
        checkOutput("t4 rst ce_n", {31'h0, sramCeN}, 32'h1);
        checkOutput("t4 rst oe_n", {31'h0, sramOeN}, 32'h1);
        checkOutput("t4 rst we_n", {31'h0, sramWeN}, 32'h1);
        checkOutput("t4 rst drive", {31'h0, sramDrive}, 32'h0);
        checkOutput("t4 rst addr", {12'h0, sramAddr}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        nextCycle(); @(negedge clk);
        checkOutput("t4 r1 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t4 r1 addr", {12'h0, sramAddr}, 32'h30);
        checkOutput("t4 r1 done", {31'h0, instDone}, 32'h0);
        checkOutput("t4 r1 rdata", instRdata, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t4 r2 done", {31'h0, instDone}, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t4 r3 done", {31'h0, instDone}, 32'h1);
        checkOutput("t4 r3 rdata", instRdata, 32'hC0DE0030);

        // Request dropped while the access is in flight
        nextCycle();
        applyStimulus(1, 20'h40, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t6 c1 ce_n", {31'h0, sramCeN}, 32'h0);
        checkOutput("t6 c1 stall", {31'h0, stall}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t6 c2 ce_n", {31'h0, sramCeN}, 32'h0);
        nextCycle(); @(negedge clk);
        checkOutput("t6 c3 done", {31'h0, instDone}, 32'h1);
        checkOutput("t6 c3 rdata", instRdata, 32'hC0DE0040);
        nextCycle(); @(negedge clk);
        checkOutput("t6 c4 done", {31'h0, instDone}, 32'h0);
        checkOutput("t6 c4 ce_n", {31'h0, sramCeN}, 32'h1);
        nextCycle(); @(negedge clk);
        checkOutput("t6 c5 done", {31'h0, instDone}, 32'h0);
        checkOutput("t6 c5 ce_n", {31'h0, sramCeN}, 32'h1);

        // Back-to-back fetches of 0,1,2: periods 3 (WAIT_CYCLES=0) and 6 (WAIT_CYCLES=3)
        nextCycle();
        for (int c = 0; c < 20; c++) begin
            logic expDone0, expCe0, expDone3, expCe3;
            w0InstReq  = (c < 9);
            w0InstAddr = 20'(c / 3);
            w3InstReq  = (c < 18);
            w3InstAddr = 20'(c / 6);
            expDone0 = (c < 9) && (c % 3 == 2);
            expCe0   = (c < 9) && (c % 3 == 1);
            expDone3 = (c < 18) && (c % 6 == 5);
            expCe3   = (c < 18) && (c % 6 >= 1) && (c % 6 <= 4);
            @(negedge clk);
            checkOutput($sformatf("w0 c%0d done", c), {31'h0, w0InstDone}, {31'h0, expDone0});
            checkOutput($sformatf("w0 c%0d ce_n", c), {31'h0, w0CeN}, {31'h0, ~expCe0});
            checkOutput($sformatf("w0 c%0d oe_n", c), {31'h0, w0OeN}, {31'h0, ~expCe0});
            checkOutput($sformatf("w0 c%0d stall", c), {31'h0, w0Stall}, {31'h0, w0InstReq & ~expDone0});
            if (expDone0) begin
                checkOutput($sformatf("w0 c%0d rdata", c), w0InstRdata, 32'hC0DE0000 | 32'(c / 3));
            end
            checkOutput($sformatf("w3 c%0d done", c), {31'h0, w3InstDone}, {31'h0, expDone3});
            checkOutput($sformatf("w3 c%0d ce_n", c), {31'h0, w3CeN}, {31'h0, ~expCe3});
            checkOutput($sformatf("w3 c%0d oe_n", c), {31'h0, w3OeN}, {31'h0, ~expCe3});
            checkOutput($sformatf("w3 c%0d stall", c), {31'h0, w3Stall}, {31'h0, w3InstReq & ~expDone3});
            if (expDone3) begin
                checkOutput($sformatf("w3 c%0d rdata", c), w3InstRdata, 32'hC0DE0000 | 32'(c / 6));
            end
            nextCycle();
        end
        checkOutput("sweep we_n", {30'h0, w0WeN, w3WeN}, 32'h3);
        checkOutput("sweep drive", {30'h0, w0SramDrive, w3SramDrive}, 32'h0);
        checkOutput("sweep data done", {30'h0, w0DataDone, w3DataDone}, 32'h0);
        checkOutput("sweep w0 data rdata", w0DataRdata, 32'h0);
        checkOutput("sweep w3 data rdata", w3DataRdata, 32'h0);
        checkOutput("sweep wdata", w0SramWdata | w3SramWdata, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single external SRAM shared by instruction fetch (IF stage, read-only) and data access (MEM stage, read/write).
- Fixed-priority arbiter plus multi-cycle access FSM.
- Drives SRAM control/address/data and a stall request that freezes the pipeline until the pending access completes.
- Sits between cpu top-level fetch/MEM ports and the board SRAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, data word width
WAIT_CYCLES, 1, extra SRAM cycles per access (access phase = WAIT_CYCLES+1 cycles), legal 0..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
inst_req_i  input  1  fetch request, held until inst_done_o
inst_addr_i  input  ADDR_W  fetch address
inst_rdata_o  output  DATA_W  fetched word, valid when inst_done_o=1
inst_done_o  output  1  one-cycle completion pulse for fetch
data_req_i  input  1  data request, held until data_done_o
data_we_i  input  1  1=write, 0=read
data_addr_i  input  ADDR_W  data address
data_wdata_i  input  DATA_W  write data
data_rdata_o  output  DATA_W  read word, valid when data_done_o=1
data_done_o  output  1  one-cycle completion pulse for data
stall_o  output  1  pipeline stall request
sram_addr_o  output  ADDR_W  SRAM address
sram_wdata_o  output  DATA_W  SRAM write data
sram_drive_o  output  1  top-level tristate enable for sram_wdata_o
sram_rdata_i  input  DATA_W  SRAM read data
sram_ce_n_o  output  1  chip enable, active low
sram_oe_n_o  output  1  output enable, active low
sram_we_n_o  output  1  write enable, active low

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, grant=none.
  - sram_ce_n_o/oe_n_o/we_n_o=1, sram_drive_o=0, sram_addr_o=0, sram_wdata_o=0.
  - Both done=0, both rdata=0.
  - Reset mid-access abandons the access; no done pulse is issued.
- States: IDLE, ACCESS, DONE. All outputs are registered except stall_o.
- IDLE:
  - data_req_i=1 → grant DATA (strict priority, data wins a tie).
  - Else inst_req_i=1 → grant INST.
  - Else stay in IDLE.
  - On grant: latch address, we (INST forces read) and wdata; go to ACCESS with cnt=0.
- ACCESS:
  - Outputs: ce_n=0; sram_addr_o=latched address.
  - Read: oe_n=0, we_n=1, drive=0.
  - Write: oe_n=1, we_n=0, drive=1, sram_wdata_o=latched wdata.
  - cnt increments each cycle. When cnt==WAIT_CYCLES: for reads, capture sram_rdata_i into the granted port's rdata register; go to DONE.
- DONE (1 cycle):
  - SRAM controls deasserted (ce_n=oe_n=we_n=1, drive=0).
  - Granted port's done=1; its rdata holds the captured word (writes leave rdata unchanged).
  - Next state IDLE.
  - The other port's done and rdata are unchanged.
- Latency: req asserted in IDLE cycle 0 → ACCESS cycles 1..WAIT_CYCLES+1 → done in cycle WAIT_CYCLES+2. IDLE on the following cycle; back-to-back accesses cost WAIT_CYCLES+3 cycles each.
- rdata holds its value until that port's next completed read.
- stall_o = (inst_req_i & ~inst_done_o) | (data_req_i & ~data_done_o), combinational.
- Requester obligations: hold addr/we/wdata stable while req=1. Dropping req during ACCESS does not abort; the access completes and done still pulses.
- A req still high in the IDLE cycle after done is treated as a new request.
- A pending INST request waits while DATA is being served. Once DATA completes and IDLE is reached, INST is granted if data_req_i=0.
- A new data_req_i during an INST access takes effect only at the next IDLE.
- Starvation of INST by continuous DATA is permitted; the pipeline guarantees data_req_i drops after data_done_o.

Test Plan:
1. Reset then single fetch, WAIT_CYCLES=1: inst_req_i=1, addr=0x00010; SRAM model returns 0xDEADBEEF → ce_n/oe_n low cycles 1–2, inst_done_o=1 in cycle 3 with inst_rdata_o=0xDEADBEEF, stall_o=1 cycles 0–2, 0 in cycle 3.
2. Simultaneous requests: inst_req_i=1 (0x00004) and data write 0x00100 := 0x12345678 in the same cycle → data served first (we_n low, drive=1, addr 0x00100, done cycle 3), IDLE in cycle 4, inst access cycles 5–6, inst_done_o cycle 7; memory[0x100]=0x12345678.
3. Data read during in-flight fetch: data_req_i asserted in cycle 1 of an INST access → INST completes in cycle 3; DATA granted in cycle 4; data_done_o in cycle 7 with correct word; inst_rdata_o unchanged throughout.
4. Async reset mid-access: assert rst=0 in ACCESS cycle 1 (no clock edge) → all SRAM controls return to 1 and drive to 0 immediately. After rst=1 with req held, the access restarts from IDLE with full latency and no spurious done.
5. Parameter sweep WAIT_CYCLES=0 and 3: the ACCESS phase lasts 1 and 4 cycles; done arrives at cycle 2 and 5 respectively; back-to-back fetches to 0,1,2 complete every 3 and 6 cycles.
6. Req dropped mid-access: inst_req_i deasserted in ACCESS → access still completes, inst_done_o pulses once, FSM returns to IDLE and stays idle.
